// File: rtl/instr_encoder_loader.sv
// Packs symbolic MIPS op requests into 32-bit instruction words and streams
// them into instruction memory through a small FIFO and a registered write port.
package AluCtrlSig_pkg;
   localparam logic [5:0] LW_op   = 6'h23;
   localparam logic [5:0] SW_op   = 6'h2B;
   localparam logic [5:0] ADDI_op = 6'h08;
   localparam logic [5:0] BEQ_op  = 6'h04;
   localparam logic [5:0] BNE_op  = 6'h05;
   localparam logic [5:0] ADD_op  = 6'h00;
   localparam logic [5:0] J_op    = 6'h02;
endpackage

module instr_encoder_loader
   import AluCtrlSig_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int MEM_WORDS  = 256,
   parameter int FIFO_DEPTH = 4,
   parameter int BASE_ADDR  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              finish,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [2:0]        op_kind,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   input  logic              imem_stall,
   output logic              busy,
   output logic              load_done,
   output logic              illegal_op,
   output logic [ADDR_W:0]   words_written
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [5:0] ADD_FUNCT = 6'h20;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
   state_t state, state_nx;

   logic [31:0]   fifo_mem [FIFO_DEPTH];
   logic [PW:0]   wptr, rptr;
   logic [ADDR_W:0] reserved;
   logic [31:0]   enc_word;
   logic fifo_empty, fifo_full, accept, legal, push, pop, taken;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign fifo_empty = (wptr == rptr);
   assign fifo_full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
   assign op_ready   = (state == LOAD) && !fifo_full && (reserved < LIMIT);
   assign accept     = op_valid && op_ready;
   assign legal      = (op_kind != 3'd7);
   assign push       = accept && legal && !start;
   assign taken      = imem_we && !imem_stall;
   assign pop        = (!imem_we || taken) && !fifo_empty;
   assign busy       = (state == LOAD) || (state == DRAIN);
   assign load_done  = (state == DONE);

   always_comb begin
      enc_word = '0;
      case (op_kind)
         3'd0:    enc_word = {LW_op, rs, rt, imm};
         3'd1:    enc_word = {SW_op, rs, rt, imm};
         3'd2:    enc_word = {ADDI_op, rs, rt, imm};
         3'd3:    enc_word = {BEQ_op, rs, rt, imm};
         3'd4:    enc_word = {BNE_op, rs, rt, imm};
         3'd5:    enc_word = {ADD_op, rs, rt, rd, 5'd0, ADD_FUNCT};
         3'd6:    enc_word = {J_op, target};
         default: enc_word = '0;
      endcase
   end

   always_comb begin
      state_nx = state;
      if (start) state_nx = LOAD;
      else begin
         case (state)
            LOAD:    if (finish) state_nx = DRAIN;
            // Leave as the final write is taken so load_done rises right after it.
            DRAIN:   if (fifo_empty && (!imem_we || taken)) state_nx = DONE;
            default: state_nx = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wptr          <= '0;
         rptr          <= '0;
         reserved      <= '0;
         illegal_op    <= 1'b0;
         imem_we       <= 1'b0;
         imem_addr     <= BASE;
         imem_wdata    <= '0;
         words_written <= '0;
      end else begin
         state <= state_nx;
         if (start) begin
            wptr          <= '0;
            rptr          <= '0;
            reserved      <= '0;
            illegal_op    <= 1'b0;
            imem_we       <= 1'b0;
            imem_addr     <= BASE;
            words_written <= '0;
         end else begin
            if (push) begin
               wptr     <= wptr + 1'b1;
               reserved <= reserved + 1'b1;
            end
            if (accept && !legal) illegal_op <= 1'b1;
            if (taken) begin
               imem_addr     <= imem_addr + 1'b1;
               words_written <= words_written + 1'b1;
            end
            if (pop) begin
               imem_wdata <= fifo_mem[rptr[PW-1:0]];
               imem_we    <= 1'b1;
               rptr       <= rptr + 1'b1;
            end else if (taken) begin
               imem_we <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr[PW-1:0]] <= enc_word;
   end
endmodule
